// File: rtl/missile_ctl.sv
// Single-missile launch/flight/cooldown controller feeding the missile draw stage.
// Positions move only on the vsync rising edge so a rendered frame is never split.
module missile_ctl #(
  parameter int SPEED           = 8,
  parameter int MISSILE_H       = 20,
  parameter int TOP_LIMIT       = 0,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        fire,
  input  logic [11:0] ship_xpos,
  input  logic [11:0] ship_ypos,
  input  logic        vsync_in,
  input  logic        hit,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        on,
  output logic        fired,
  output logic [1:0]  state_dbg
);

  // Handshake: none. fire and hit are level/strobe inputs sampled every pclk
  // edge; fired is a single-cycle pulse with no back-pressure.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [11:0]     LAUNCH_MIN = 12'(MISSILE_H + SPEED + TOP_LIMIT);
  localparam logic [11:0]     EXIT_LIM   = 12'(TOP_LIMIT + SPEED);
  localparam logic [11:0]     STEP       = 12'(SPEED);
  localparam logic [11:0]     HEIGHT     = 12'(MISSILE_H);
  localparam logic [CD_W-1:0] CD_LOAD    = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE     = CD_W'(1);

  state_t          state_q, state_d;
  logic [11:0]     xpos_q, xpos_d;
  logic [11:0]     ypos_q, ypos_d;
  logic            fired_q, fired_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            vsync_d;
  logic            fire_d;

  logic tick;
  logic fire_rise;

  assign tick      = vsync_in & ~vsync_d;
  assign fire_rise = fire & ~fire_d;

  // fire_d resets high so a button held through reset release cannot launch.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xpos_q  <= '0;
      ypos_q  <= '0;
      fired_q <= 1'b0;
      cd_q    <= '0;
      vsync_d <= 1'b0;
      fire_d  <= 1'b1;
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      fired_q <= fired_d;
      cd_q    <= cd_d;
      vsync_d <= vsync_in;
      fire_d  <= fire;
    end
  end

  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    fired_d = 1'b0;
    cd_d    = cd_q;
    case (state_q)
      IDLE: begin
        // The launch bound guarantees the first upward step cannot wrap.
        if (fire_rise && (ship_ypos >= LAUNCH_MIN)) begin
          state_d = FLY;
          xpos_d  = ship_xpos;
          ypos_d  = ship_ypos - HEIGHT;
          fired_d = 1'b1;
        end
      end
      FLY: begin
        if (hit) begin
          state_d = COOLDOWN;
          cd_d    = CD_LOAD;
        end else if (tick) begin
          if (ypos_q < EXIT_LIM) begin
            state_d = COOLDOWN;
            cd_d    = CD_LOAD;
          end else begin
            ypos_d = ypos_q - STEP;
          end
        end
      end
      COOLDOWN: begin
        // A zero load (no cooldown configured) leaves on the very next edge.
        if (cd_q == '0) begin
          state_d = IDLE;
        end else if (tick) begin
          cd_d = cd_q - CD_ONE;
          if (cd_q == CD_ONE) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign on        = (state_q == FLY);
  assign fired     = fired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_missile_ctl.sv
// Bench for missile_ctl: table of per-cycle vectors plus hand-written reset
// sequences; expected output words are queued on drive and popped on sample.
module tb_missile_ctl;

  logic        pclk;
  logic        rst_n;
  logic        fire;
  logic [11:0] ship_xpos;
  logic [11:0] ship_ypos;
  logic        vsync_in;
  logic        hit;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        on;
  logic        fired;
  logic [1:0]  state_dbg;

  localparam int W = 28;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FLY  = 2'd1;
  localparam logic [1:0] S_CD   = 2'd2;

  typedef struct {
    logic        fire;
    logic        vs;
    logic        hit;
    logic [11:0] sx;
    logic [11:0] sy;
    logic [1:0]  st;
    logic        on;
    logic        fired;
    logic [11:0] x;
    logic [11:0] y;
  } vec_t;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  vec_t         tbl[$];
  int           errors = 0;
  int           checks = 0;

  missile_ctl #(
    .SPEED(8), .MISSILE_H(20), .TOP_LIMIT(0), .COOLDOWN_FRAMES(4)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .fire(fire), .ship_xpos(ship_xpos),
    .ship_ypos(ship_ypos), .vsync_in(vsync_in), .hit(hit), .xpos(xpos),
    .ypos(ypos), .on(on), .fired(fired), .state_dbg(state_dbg)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic vec_t mk(input logic f, input logic v, input logic h,
                              input int sx, input int sy, input logic [1:0] st,
                              input logic o, input logic fd, input int x, input int y);
    vec_t r;
    r.fire = f; r.vs = v; r.hit = h;
    r.sx = 12'(sx); r.sy = 12'(sy);
    r.st = st; r.on = o; r.fired = fd;
    r.x = 12'(x); r.y = 12'(y);
    return r;
  endfunction

  // scoreboard
  task automatic expect_word(input logic [W-1:0] w, input string name);
    exp_q.push_back(w);
    name_q.push_back(name);
  endtask

  task automatic check_out();
    logic [W-1:0] got, want;
    string nm;
    want = exp_q.pop_front();
    nm   = name_q.pop_front();
    got  = {state_dbg, on, fired, xpos, ypos};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got st=%0d on=%0b fired=%0b x=%0d y=%0d, want st=%0d on=%0b fired=%0b x=%0d y=%0d",
               nm, got[27:26], got[25], got[24], got[23:12], got[11:0],
               want[27:26], want[25], want[24], want[23:12], want[11:0]);
    end
  endtask

  // driver: called at a negedge, drives one cycle, samples at the next negedge
  task automatic apply(input vec_t v, input string name);
    fire      = v.fire;
    vsync_in  = v.vs;
    hit       = v.hit;
    ship_xpos = v.sx;
    ship_ypos = v.sy;
    expect_word({v.st, v.on, v.fired, v.x, v.y}, name);
    @(negedge pclk);
    check_out();
  endtask

  initial begin
    rst_n = 1'b0; fire = 1'b1; vsync_in = 1'b0; hit = 1'b0;
    ship_xpos = 12'd400; ship_ypos = 12'd500;

    // reset state with fire held
    repeat (3) @(negedge pclk);
    expect_word('0, "reset_state");
    check_out();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      apply(mk(1, 0, 0, 400, 500, S_IDLE, 0, 0, 0, 0), $sformatf("held_fire_reset%0d", i));

    // launch, flight, hit-over-tick, cooldown, rejected launch, top exit, held fire
    tbl.push_back(mk(0, 0, 0, 400, 500, S_IDLE, 0, 0,   0,   0));
    tbl.push_back(mk(1, 0, 0, 400, 500, S_FLY,  1, 1, 400, 480));
    tbl.push_back(mk(1, 0, 0, 400, 500, S_FLY,  1, 0, 400, 480));
    tbl.push_back(mk(0, 1, 0, 400, 500, S_FLY,  1, 0, 400, 472));
    tbl.push_back(mk(0, 0, 0, 400, 500, S_FLY,  1, 0, 400, 472));
    tbl.push_back(mk(1, 1, 0, 400, 500, S_FLY,  1, 0, 400, 464));
    tbl.push_back(mk(0, 0, 0, 400, 500, S_FLY,  1, 0, 400, 464));
    tbl.push_back(mk(0, 1, 0, 400, 500, S_FLY,  1, 0, 400, 456));
    tbl.push_back(mk(0, 0, 0, 400, 500, S_FLY,  1, 0, 400, 456));
    tbl.push_back(mk(0, 1, 1, 400, 500, S_CD,   0, 0, 400, 456));
    tbl.push_back(mk(0, 0, 0, 400, 500, S_CD,   0, 0, 400, 456));
    tbl.push_back(mk(1, 1, 0, 400, 500, S_CD,   0, 0, 400, 456));
    tbl.push_back(mk(0, 0, 0, 400, 500, S_CD,   0, 0, 400, 456));
    tbl.push_back(mk(0, 1, 0, 400, 500, S_CD,   0, 0, 400, 456));
    tbl.push_back(mk(0, 0, 0, 400, 500, S_CD,   0, 0, 400, 456));
    tbl.push_back(mk(0, 1, 0, 400, 500, S_CD,   0, 0, 400, 456));
    tbl.push_back(mk(0, 0, 0, 400, 500, S_CD,   0, 0, 400, 456));
    tbl.push_back(mk(0, 1, 0, 400, 500, S_IDLE, 0, 0, 400, 456));
    tbl.push_back(mk(0, 0, 1, 400, 500, S_IDLE, 0, 0, 400, 456));
    tbl.push_back(mk(1, 1, 0, 400,  25, S_IDLE, 0, 0, 400, 456));
    tbl.push_back(mk(0, 0, 0, 400,  25, S_IDLE, 0, 0, 400, 456));
    tbl.push_back(mk(1, 0, 0, 100,  30, S_FLY,  1, 1, 100,  10));
    tbl.push_back(mk(0, 0, 0, 100,  30, S_FLY,  1, 0, 100,  10));
    tbl.push_back(mk(0, 1, 0, 100,  30, S_FLY,  1, 0, 100,   2));
    tbl.push_back(mk(0, 0, 0, 100,  30, S_FLY,  1, 0, 100,   2));
    tbl.push_back(mk(0, 1, 0, 100,  30, S_CD,   0, 0, 100,   2));
    tbl.push_back(mk(1, 0, 0, 100,  30, S_CD,   0, 0, 100,   2));
    tbl.push_back(mk(0, 1, 0, 100,  30, S_CD,   0, 0, 100,   2));
    tbl.push_back(mk(0, 0, 0, 100,  30, S_CD,   0, 0, 100,   2));
    tbl.push_back(mk(0, 1, 0, 100,  30, S_CD,   0, 0, 100,   2));
    tbl.push_back(mk(0, 0, 0, 100,  30, S_CD,   0, 0, 100,   2));
    tbl.push_back(mk(0, 1, 0, 100,  30, S_CD,   0, 0, 100,   2));
    tbl.push_back(mk(1, 0, 0, 100,  30, S_CD,   0, 0, 100,   2));
    tbl.push_back(mk(1, 1, 0, 100,  30, S_IDLE, 0, 0, 100,   2));
    tbl.push_back(mk(1, 0, 0, 100,  30, S_IDLE, 0, 0, 100,   2));
    tbl.push_back(mk(0, 0, 0, 100,  30, S_IDLE, 0, 0, 100,   2));
    tbl.push_back(mk(1, 1, 0, 100,  30, S_FLY,  1, 1, 100,  10));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // asynchronous reset between edges while flying
    fire = 1'b0;
    vsync_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_word('0, "async_reset_mid_fly");
    check_out();
    @(negedge pclk);
    rst_n = 1'b1;
    apply(mk(0, 1, 0, 400, 500, S_IDLE, 0, 0,   0,   0), "post_reset_tick");
    apply(mk(1, 0, 0, 400, 500, S_FLY,  1, 1, 400, 480), "post_reset_launch");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
